response_router: RTL and testbench

RESPONSE_ROUTER -- requirements
Module: response_router

---
 rtl/response_router.sv | 98 +++++++++
 tb/tb_response_router.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/response_router.sv
// response_router: splits a response stream into two per-port FIFOs by ID MSB
//   clk                      rising-edge clock
//   reset                    synchronous, active-low reset
//   in_data/in_id/in_valid   response from the shared resource
//   out_stall                upstream backpressure (either queue full)
//   out_data_n/out_id_n      head of queue n
//   out_valid_n              queue n non-empty
//   in_stall_n               consumer backpressure for port n
//   delivered_n              wrapping count of pops at port n
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
module response_router #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`DATA_WIDTH-1:0] in_data,
    input  logic [`ID_WIDTH-1:0]   in_id,
    input  logic                   in_valid,
    output logic                   out_stall,
    output logic [`DATA_WIDTH-1:0] out_data_1,
    output logic [`DATA_WIDTH-1:0] out_data_2,
    output logic [`ID_WIDTH-1:0]   out_id_1,
    output logic [`ID_WIDTH-1:0]   out_id_2,
    output logic                   out_valid_1,
    output logic                   out_valid_2,
    input  logic                   in_stall_1,
    input  logic                   in_stall_2,
    output logic [CNT_WIDTH-1:0]   delivered_1,
    output logic [CNT_WIDTH-1:0]   delivered_2
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [`DATA_WIDTH-1:0] w_head_data [2];
    logic [`ID_WIDTH-1:0]   w_head_id   [2];
    logic [CNT_WIDTH-1:0]   w_dlv       [2];
    logic [1:0]             w_valid;
    logic [1:0]             w_full;
    logic [1:0]             w_in_stall;

    assign w_in_stall = {in_stall_2, in_stall_1};
    // derived from registered counts only, so no path from in_valid/in_id
    assign out_stall  = |w_full;

    for (genvar p = 0; p < 2; p++) begin : g_q
        logic [`DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
        logic [`ID_WIDTH-1:0]   r_id   [FIFO_DEPTH];
        logic [AW-1:0]          r_wp;
        logic [AW-1:0]          r_rp;
        logic [AW:0]            r_cnt;
        logic [CNT_WIDTH-1:0]   r_dlv;
        logic                   w_push;
        logic                   w_pop;

        assign w_push         = in_valid && !out_stall && (in_id[`ID_WIDTH-1] == 1'(p));
        assign w_pop          = w_valid[p] && !w_in_stall[p];
        assign w_valid[p]     = r_cnt != '0;
        assign w_full[p]      = r_cnt == (AW+1)'(FIFO_DEPTH);
        assign w_head_data[p] = r_data[r_rp];
        assign w_head_id[p]   = r_id[r_rp];
        assign w_dlv[p]       = r_dlv;

        // pointers are AW bits wide, so they wrap modulo FIFO_DEPTH naturally
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_dlv <= '0;
            end else begin
                if (w_push) begin
                    r_data[r_wp] <= in_data;
                    r_id[r_wp]   <= in_id;
                    r_wp         <= r_wp + AW'(1);
                end
                if (w_pop) begin
                    r_rp  <= r_rp + AW'(1);
                    r_dlv <= r_dlv + CNT_WIDTH'(1);
                end
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end

    assign out_data_1  = w_head_data[0];
    assign out_data_2  = w_head_data[1];
    assign out_id_1    = w_head_id[0];
    assign out_id_2    = w_head_id[1];
    assign out_valid_1 = w_valid[0];
    assign out_valid_2 = w_valid[1];
    assign delivered_1 = w_dlv[0];
    assign delivered_2 = w_dlv[1];
endmodule

// File: tb/tb_response_router.sv
// tb_response_router: table vectors, directed corner cases and a queue-model random test
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
module tb_response_router;
    localparam int DW = `DATA_WIDTH;
    localparam int IW = `ID_WIDTH;

    logic          clk = 0;
    logic          reset = 0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] in_id = '0;
    logic          in_valid = 0;
    logic          out_stall;
    logic [DW-1:0] out_data_1, out_data_2;
    logic [IW-1:0] out_id_1, out_id_2;
    logic          out_valid_1, out_valid_2;
    logic          in_stall_1 = 0, in_stall_2 = 0;
    logic [3:0]    delivered_1, delivered_2;

    int errors = 0;
    int checks = 0;

    response_router #(.FIFO_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
        .out_stall(out_stall),
        .out_data_1(out_data_1), .out_data_2(out_data_2),
        .out_id_1(out_id_1), .out_id_2(out_id_2),
        .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .in_stall_1(in_stall_1), .in_stall_2(in_stall_2),
        .delivered_1(delivered_1), .delivered_2(delivered_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 0;
        in_valid = 0;
        in_stall_1 = 0;
        in_stall_2 = 0;
        tick;
        chk("rst_valid1", 32'(out_valid_1), 0);
        chk("rst_valid2", 32'(out_valid_2), 0);
        chk("rst_stall", 32'(out_stall), 0);
        chk("rst_dlv1", 32'(delivered_1), 0);
        chk("rst_dlv2", 32'(delivered_2), 0);
        reset = 1;
    endtask

    typedef struct {
        logic          v;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        logic          s1, s2;
        logic          ev1;
        logic [DW-1:0] ed1;
        logic          ev2;
        logic [DW-1:0] ed2;
        logic          est;
        logic [3:0]    dl1, dl2;
    } vec_t;

    vec_t tbl[12];

    logic [IW+DW-1:0] mq1[$], mq2[$];
    logic [DW-1:0]    got[$];

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, 4'h8, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 4'd0, 4'd0};
        tbl[2]  = '{1'b0, 4'h8, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 4'd1, 4'd0};
        tbl[3]  = '{1'b1, 4'h3, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 4'd1, 4'd1};
        tbl[4]  = '{1'b1, 4'h0, 8'h44, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 4'd2, 4'd1};
        tbl[5]  = '{1'b1, 4'hF, 8'h55, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 4'd2, 4'd1};
        tbl[6]  = '{1'b1, 4'h8, 8'h66, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 4'd2, 4'd1};
        tbl[7]  = '{1'b1, 4'h8, 8'h77, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 4'd2, 4'd1};
        tbl[8]  = '{1'b1, 4'h8, 8'h88, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 4'd2, 4'd1};
        tbl[9]  = '{1'b1, 4'h0, 8'h99, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 4'd2, 4'd1};
        tbl[10] = '{1'b1, 4'h0, 8'h99, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 8'h66, 1'b0, 4'd2, 4'd2};
        tbl[11] = '{1'b1, 4'h0, 8'h99, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 8'h77, 1'b0, 4'd2, 4'd3};

        // table-driven vectors
        do_reset;
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].v;
            in_id = tbl[i].id;
            in_data = tbl[i].d;
            in_stall_1 = tbl[i].s1;
            in_stall_2 = tbl[i].s2;
            tick;
            chk($sformatf("tbl%0d_v1", i), 32'(out_valid_1), 32'(tbl[i].ev1));
            chk($sformatf("tbl%0d_v2", i), 32'(out_valid_2), 32'(tbl[i].ev2));
            chk($sformatf("tbl%0d_stall", i), 32'(out_stall), 32'(tbl[i].est));
            chk($sformatf("tbl%0d_dl1", i), 32'(delivered_1), 32'(tbl[i].dl1));
            chk($sformatf("tbl%0d_dl2", i), 32'(delivered_2), 32'(tbl[i].dl2));
            if (tbl[i].ev1) chk($sformatf("tbl%0d_d1", i), 32'(out_data_1), 32'(tbl[i].ed1));
            if (tbl[i].ev2) chk($sformatf("tbl%0d_d2", i), 32'(out_data_2), 32'(tbl[i].ed2));
        end

        // single response to port 1, then popped
        do_reset;
        in_valid = 1; in_id = 4'h0; in_data = 8'hA5;
        tick;
        in_valid = 0;
        chk("a5_v1", 32'(out_valid_1), 1);
        chk("a5_d1", 32'(out_data_1), 32'h A5);
        chk("a5_v2", 32'(out_valid_2), 0);
        tick;
        chk("a5_v1_after", 32'(out_valid_1), 0);
        chk("a5_dlv1", 32'(delivered_1), 1);
        chk("a5_dlv2", 32'(delivered_2), 0);
        chk("a5_v2_after", 32'(out_valid_2), 0);

        // fill port 2, hold a 5th response, then drain in order
        do_reset;
        in_stall_2 = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_id = 4'h8 | 4'(i); in_data = 8'hB0 + 8'(i);
            tick;
            chk($sformatf("full_stall%0d", i), 32'(out_stall), (i == 3) ? 1 : 0);
        end
        in_data = 8'hB4; in_id = 4'hC;
        tick;
        tick;
        chk("full_hold_stall", 32'(out_stall), 1);
        chk("full_hold_head", 32'(out_data_2), 32'h B0);
        in_stall_2 = 0;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            logic acc;
            acc = in_valid && !out_stall;
            if (out_valid_2) got.push_back(out_data_2);
            tick;
            if (acc) in_valid = 0;
        end
        chk("full_count", 32'(got.size()), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("full_order%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hX, 32'h B0 + 32'(i));
        chk("full_dlv2", 32'(delivered_2), 5);

        // push and pop the same queue at count=1
        do_reset;
        in_stall_1 = 1; in_stall_2 = 1;
        in_valid = 1; in_id = 4'h1; in_data = 8'hC1;
        tick;
        in_id = 4'h9; in_data = 8'hC2;
        tick;
        in_stall_1 = 0; in_id = 4'h2; in_data = 8'hC3;
        tick;
        in_valid = 0; in_stall_1 = 1;
        chk("pp_v1", 32'(out_valid_1), 1);
        chk("pp_d1", 32'(out_data_1), 32'h C3);
        chk("pp_id1", 32'(out_id_1), 32'h2);
        chk("pp_dlv1", 32'(delivered_1), 1);
        chk("pp_d2", 32'(out_data_2), 32'h C2);
        in_stall_1 = 0;
        tick;
        chk("pp_v1_empty", 32'(out_valid_1), 0);
        chk("pp_v2_kept", 32'(out_valid_2), 1);

        // reset discards queued entries, even with a same-cycle push
        do_reset;
        in_stall_1 = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_id = 4'h0; in_data = 8'hD1 + 8'(i);
            tick;
        end
        reset = 0; in_stall_1 = 0; in_data = 8'hDD;
        tick;
        chk("rq_v1", 32'(out_valid_1), 0);
        chk("rq_dlv1", 32'(delivered_1), 0);
        chk("rq_stall", 32'(out_stall), 0);
        reset = 1; in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("rq_idle%0d", i), 32'(out_valid_1), 0);
        end
        in_valid = 1; in_data = 8'hE1; in_stall_1 = 1;
        tick;
        in_valid = 0;
        chk("rq_fresh", 32'(out_data_1), 32'h E1);
        chk("rq_dlv1_still0", 32'(delivered_1), 0);

        // delivered counter wrap (4-bit counter)
        do_reset;
        for (int i = 0; i <= 16; i++) begin
            in_valid = 1; in_id = 4'h0; in_data = 8'(i);
            tick;
            chk($sformatf("wrap%0d", i), 32'(delivered_1), 32'(i % 16));
        end
        in_valid = 0;

        // random alternating traffic against a queue model
        do_reset;
        begin
            int sent = 0, cyc = 0;
            logic [3:0] md1 = 0, md2 = 0;
            mq1.delete(); mq2.delete();
            while ((sent < 100 || mq1.size() != 0 || mq2.size() != 0) && cyc < 4000) begin
                logic mstall, pop1, pop2, push;
                if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1;
                    in_id = {sent[0], 3'($urandom)};
                    in_data = 8'($urandom);
                end
                in_stall_1 = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_stall_2 = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
                mstall = (mq1.size() == 4) || (mq2.size() == 4);
                chk("rnd_stall", 32'(out_stall), 32'(mstall));
                chk("rnd_v1", 32'(out_valid_1), 32'(mq1.size() != 0));
                chk("rnd_v2", 32'(out_valid_2), 32'(mq2.size() != 0));
                if (mq1.size() != 0) chk("rnd_head1", 32'({out_id_1, out_data_1}), 32'(mq1[0]));
                if (mq2.size() != 0) chk("rnd_head2", 32'({out_id_2, out_data_2}), 32'(mq2[0]));
                pop1 = mq1.size() != 0 && !in_stall_1;
                pop2 = mq2.size() != 0 && !in_stall_2;
                push = in_valid && !mstall;
                tick;
                cyc++;
                if (pop1) begin void'(mq1.pop_front()); md1++; end
                if (pop2) begin void'(mq2.pop_front()); md2++; end
                if (push) begin
                    if (in_id[IW-1]) mq2.push_back({in_id, in_data});
                    else mq1.push_back({in_id, in_data});
                    sent++;
                    in_valid = 0;
                end
                chk("rnd_dlv1", 32'(delivered_1), 32'(md1));
                chk("rnd_dlv2", 32'(delivered_2), 32'(md2));
            end
            chk("rnd_sent", 32'(sent), 100);
            chk("rnd_drained", 32'(mq1.size() + mq2.size()), 0);
            chk("rnd_dlv_total", 32'(delivered_1) + 32'(delivered_2), 32'(100 % 16 + ((100 / 2) % 16 + 100 / 2 % 16 - 100 % 16)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
